serial_carry_adder: RTL and testbench

- Bit-serial adder stage that consumes the carry-out of the full_adder_co majority cell and closes the loop through a carry register.
- Accepts two parallel operands plus carry-in over a valid/ready handshake.
- Processes one bit per clock, LSB first: sum bit = a^b^c (XOR2 path), carry = majority(a,b,c) (full_adder_co function).
- Returns the parallel sum and final carry over a second valid/ready handshake.
- Sits between the operand-issue logic and the result consumer in BBTOP-level hierarchy.

---
 rtl/serial_carry_adder.sv | 116 +++++++++++
 tb/tb_serial_carry_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_carry_adder.sv
// serial_carry_adder: bit-serial adder, one bit per clock, LSB first.
// Operands are captured on an in_valid/in_ready handshake. The carry loop
// closes through a carry register. The parallel sum and the final carry
// are returned on an out_valid/out_ready handshake.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (in_ready high only in idle)
//   a, b, ci         operands and carry-in, sampled on the accept edge only
//   out_valid/ready  result handshake (out_valid high only in done)
//   sum, co          (a+b+ci) mod 2^WIDTH and bit WIDTH of a+b+ci
//   busy             high while shifting
module serial_carry_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_d;

  // Full-adder slice on the current LSBs: XOR sum and majority carry.
  always_comb begin
    bit_s = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    bit_c = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
    // Sum bits enter at the MSB; after WIDTH shifts the LSB lands at bit 0.
    res_d = {bit_s, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      co        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            sh_a_q   <= a;
            sh_b_q   <= b;
            carry_q  <= ci;
            cnt_q    <= '0;
            state_q  <= StShift;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StShift: begin
          sh_a_q  <= {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_q  <= {1'b0, sh_b_q[WIDTH-1:1]};
          res_q   <= res_d;
          carry_q <= bit_c;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q   <= StDone;
            sum       <= res_d;
            co        <= bit_c;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          // sum/co stay as they are here and afterwards in idle.
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_carry_adder.sv
module tb_serial_carry_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             busy;

  serial_carry_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .busy      (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    int               acc;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Monitor state
  bit               pending = 0;
  logic [WIDTH-1:0] held_s = '0;
  logic             held_c = 1'b0;
  bit               have_last = 0;
  int               busy_cnt = 0;
  bit               chk_period = 0;
  int               last_first = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic cin, input int acc);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(cin);
    e.s = full[WIDTH-1:0];
    e.c = full[WIDTH];
    e.acc = acc;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      pending  = 0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        if (!pending) begin
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got sum %0h co %0b, want no result", sum, co);
          end else begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            chk("sum", {24'b0, sum}, {24'b0, e.s});
            chk("co", {31'b0, co}, {31'b0, e.c});
            chk("latency", cyc - e.acc, WIDTH);
          end
          chk("busy_cycles", busy_cnt, WIDTH);
          if (chk_period && last_first >= 0) chk("period", cyc - last_first, WIDTH + 2);
          last_first = cyc;
          busy_cnt   = 0;
          held_s     = sum;
          held_c     = co;
          have_last  = 1;
          pending    = 1;
        end else begin
          chk("hold_sum", {24'b0, sum}, {24'b0, held_s});
          chk("hold_co", {31'b0, co}, {31'b0, held_c});
        end
        if (out_ready) pending = 0;
      end
    end
  end

  // Drives at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin);
    int n;
    a        = x;
    b        = y;
    ci       = cin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0, want 1");
    end else begin
      @(posedge clk); #1;
      q.push_back(model(x, y, cin, cyc));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(q.size() == 0 && in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !in_ready) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", q.size());
      q.delete();
    end else if (have_last) begin
      chk("idle_sum_kept", {24'b0, sum}, {24'b0, held_s});
      chk("idle_co_kept", {31'b0, co}, {31'b0, held_c});
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sum"}, {24'b0, sum}, 32'd0);
    chk({tag, "_co"}, {31'b0, co}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ta;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Directed vectors
    send(8'h0F, 8'h01, 1'b0); drain();
    send(8'hFF, 8'h01, 1'b0); drain();
    send(8'h00, 8'h00, 1'b1); drain();
    send(8'hFF, 8'hFF, 1'b1); drain();

    // Backpressure for 5 cycles with ignored in_valid pulses
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      in_valid = (i % 2 == 0);
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    drain();

    // Reset in the third cycle of shifting
    send(8'h55, 8'h33, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    check_reset_values("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    send(8'h03, 8'h04, 1'b0); drain();

    // Operands change every cycle during shifting
    send(8'h3C, 8'h81, 1'b1);
    ta = 8'h3C;
    for (int i = 0; i < WIDTH + 1; i++) begin
      ta = ~ta;
      a  = ta;
      b  = 8'($urandom);
      ci = ~ci;
      @(posedge clk); #1;
    end
    drain();

    // Back-to-back random stream
    chk_period = 1;
    last_first = -1;
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain();
    chk_period = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
